// File: rtl/wf_inflight_scheduler_pkg.sv
// rtl/wf_inflight_scheduler_pkg.sv - shared defaults, drain FSM states and helpers
package wf_inflight_scheduler_pkg;

  localparam int NUM_WF_DEF = 40;
  localparam int WFID_W_DEF = 6;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic [1:0] {
    DRAIN_IDLE = 2'd0,
    DRAIN_WAIT = 2'd1,
    DRAIN_ACK  = 2'd2
  } drain_state_e;

  // Number of retire ports (0..3) hitting one wavefront in a cycle.
  function automatic logic [1:0] count_hits(input logic a, input logic b, input logic c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

endpackage

// File: rtl/wf_inflight_cnt_slot.sv
// rtl/wf_inflight_cnt_slot.sv - one saturating in-flight counter for a wavefront
module wf_inflight_cnt_slot
  import wf_inflight_scheduler_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] count,
  output logic             is_zero,
  output logic             is_max,
  output logic             err
);

  localparam logic [CNT_W-1:0]        MAX_U = {CNT_W{1'b1}};
  localparam logic signed [CNT_W+1:0] MAX_S = $signed({2'b00, MAX_U});

  logic [CNT_W-1:0]        count_q;
  logic [CNT_W-1:0]        count_d;
  logic signed [CNT_W+1:0] sum;

  // Signed next value with two guard bits, then clamp to [0, MAX] and flag the clamp.
  always_comb begin
    sum     = $signed({2'b00, count_q})
            + $signed({{(CNT_W+1){1'b0}}, inc})
            - $signed({{CNT_W{1'b0}}, dec});
    count_d = count_q;
    err     = 1'b0;
    if (sum[CNT_W+1]) begin
      count_d = '0;
      err     = 1'b1;
    end else if (sum > MAX_S) begin
      count_d = MAX_U;
      err     = 1'b1;
    end else begin
      count_d = sum[CNT_W-1:0];
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign is_zero = (count_q == '0);
  assign is_max  = (count_q == MAX_U);

endmodule

// File: rtl/wf_inflight_scheduler.sv
// rtl/wf_inflight_scheduler.sv - per-wavefront in-flight tracker, issue mask and drain handshake
module wf_inflight_scheduler
  import wf_inflight_scheduler_pkg::*;
#(
  parameter int NUM_WF = NUM_WF_DEF,
  parameter int WFID_W = WFID_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issued_en,
  input  logic [WFID_W-1:0] issued_wfid,
  input  logic              retire_vgpr_1_en,
  input  logic [WFID_W-1:0] retire_vgpr_1_wfid,
  input  logic              retire_branch_en,
  input  logic [WFID_W-1:0] retire_branch_wfid,
  input  logic              retire_sgpr_en,
  input  logic [WFID_W-1:0] retire_sgpr_wfid,
  input  logic              drain_req,
  input  logic [WFID_W-1:0] drain_wfid,
  output logic [NUM_WF-1:0] can_issue_mask,
  output logic [NUM_WF-1:0] no_inflight_mask,
  output logic              drain_busy,
  output logic              drain_ack,
  output logic              cnt_err
);

  localparam logic [WFID_W:0] NUM_WF_W = (WFID_W+1)'(NUM_WF);

  drain_state_e      state_q, state_d;
  logic [WFID_W-1:0] dwf_q, dwf_d;
  logic              cnt_err_q, cnt_err_d;

  logic [NUM_WF-1:0] inc_vec;
  logic [NUM_WF-1:0] is_zero_vec;
  logic [NUM_WF-1:0] is_max_vec;
  logic [NUM_WF-1:0] slot_err_vec;
  logic [NUM_WF-1:0] drain_mask;
  logic [1:0]        dec_vec   [NUM_WF];
  logic [CNT_W-1:0]  count_vec [NUM_WF];

  // Event ports split into in-range (applied) and out-of-range (error only).
  logic iss_ok, vg_ok, br_ok, sg_ok;
  logic iss_oor, vg_oor, br_oor, sg_oor;
  logic dwf_in_range, dwf_zero, issue_to_draining;

  assign iss_ok  = issued_en        & ({1'b0, issued_wfid}        < NUM_WF_W);
  assign vg_ok   = retire_vgpr_1_en & ({1'b0, retire_vgpr_1_wfid} < NUM_WF_W);
  assign br_ok   = retire_branch_en & ({1'b0, retire_branch_wfid} < NUM_WF_W);
  assign sg_ok   = retire_sgpr_en   & ({1'b0, retire_sgpr_wfid}   < NUM_WF_W);
  assign iss_oor = issued_en        & ~iss_ok;
  assign vg_oor  = retire_vgpr_1_en & ~vg_ok;
  assign br_oor  = retire_branch_en & ~br_ok;
  assign sg_oor  = retire_sgpr_en   & ~sg_ok;

  for (genvar i = 0; i < NUM_WF; i++) begin : g_slot
    localparam logic [WFID_W-1:0] ID = WFID_W'(i);

    assign inc_vec[i]    = iss_ok & (issued_wfid == ID);
    assign dec_vec[i]    = count_hits(vg_ok & (retire_vgpr_1_wfid == ID),
                                      br_ok & (retire_branch_wfid == ID),
                                      sg_ok & (retire_sgpr_wfid   == ID));
    assign drain_mask[i] = drain_busy & (dwf_q == ID);

    wf_inflight_cnt_slot #(
      .CNT_W (CNT_W)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc_vec[i]),
      .dec     (dec_vec[i]),
      .count   (count_vec[i]),
      .is_zero (is_zero_vec[i]),
      .is_max  (is_max_vec[i]),
      .err     (slot_err_vec[i])
    );
  end

  // A drain target outside the tracked range has nothing in flight, so it acks straight away.
  assign dwf_in_range      = ({1'b0, dwf_q} < NUM_WF_W);
  assign dwf_zero          = dwf_in_range ? (count_vec[dwf_q] == '0) : 1'b1;
  assign issue_to_draining = issued_en & drain_busy & (issued_wfid == dwf_q);

  // Drain FSM next state: latch target in IDLE, wait for its registered count to hit zero, ack once.
  always_comb begin
    state_d = state_q;
    dwf_d   = dwf_q;
    case (state_q)
      DRAIN_IDLE: begin
        if (drain_req) begin
          state_d = DRAIN_WAIT;
          dwf_d   = drain_wfid;
        end
      end
      DRAIN_WAIT: begin
        if (dwf_zero) begin
          state_d = DRAIN_ACK;
        end
      end
      DRAIN_ACK: begin
        state_d = DRAIN_IDLE;
      end
      default: begin
        state_d = DRAIN_IDLE;
      end
    endcase
  end

  // Sticky error collects counter clamps, out-of-range ids and issues into a draining wavefront.
  always_comb begin
    cnt_err_d = cnt_err_q | (|slot_err_vec)
              | iss_oor | vg_oor | br_oor | sg_oor
              | issue_to_draining;
  end

  // Drain FSM and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DRAIN_IDLE;
      dwf_q     <= '0;
      cnt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwf_q     <= dwf_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  assign drain_busy       = (state_q != DRAIN_IDLE);
  assign drain_ack        = (state_q == DRAIN_ACK);
  assign cnt_err          = cnt_err_q;
  assign no_inflight_mask = is_zero_vec;
  assign can_issue_mask   = ~is_max_vec & ~drain_mask;

endmodule
